float_mul_arbiter: RTL and testbench
====================================

// Module: float_mul_arbiter
// PURPOSE
// - Shares one pipelined float multiplier (float_pack::float_mul) between N_REQ coprocessor requesters.
// - Round-robin arbitration, fixed latency, one result buffer per requester.
// - Sits between the copro command decoders and the multiply datapath.
// - Each requester has at most one operation in flight.
// PARAMETERS
// - N_REQ        2  number of requesters (2..8)
// - PIPE_STAGES  2  register stages after float_mul (1..4) = issue-to-result latency
// - Float format is float_pack::N_mantisse / N_exposant; FW = 1+N_exposant+N_mantisse.
// PORTS
// - clk             in   1         clock, rising edge
// - reset           in   1         synchronous, active-high
// - req_valid       in   N_REQ     requester i presents operands
// - req_op1[N_REQ]  in   FW each   float operand 1
// - req_op2[N_REQ]  in   FW each   float operand 2
// - req_ready       out  N_REQ     one-hot grant; transfer when valid&ready at clk edge
// - rsp_valid       out  N_REQ     result for requester i available
// - rsp_result[N_REQ] out FW each  float product, held stable while rsp_valid
// - rsp_ready       in   N_REQ     requester i consumes result
// - busy            out  1         any pipe stage valid or any rsp_valid set
// BEHAVIOUR
// - Reset (clk edge with reset=1):
//   - pipe valids, pending[], rsp_valid[] -> 0; rr_ptr -> 0; rsp_result -> 0.
//   - req_ready and busy read 0 while reset is high.
//   - Any in-flight operation is discarded and never returned.
// - State per requester: pending[i] is set on grant and cleared on the rsp_valid&rsp_ready edge.
// - Eligibility: eligible[i] = req_valid[i] & ~pending[i] (registered pending only).
// - Grant: req_ready = one-hot pick of the first eligible index at or after rr_ptr, wrapping N_REQ-1 -> 0.
//   - req_ready is combinational from req_valid and registers; at most one grant per cycle.
// - Pointer: after a grant to i, rr_ptr <= (i+1) mod N_REQ; without a grant rr_ptr holds.
// - Issue: at the grant edge, float_mul(op1,op2) plus a requester tag enter stage 1.
//   - Stages shift every cycle; there is no pipeline stall.
// - Latency: grant in cycle t -> rsp_valid[i]=1 in cycle t+PIPE_STAGES.
//   - When the last stage exits, rsp_result[i] <= data and rsp_valid[i] <= 1.
// - Why no stall is needed: the buffer is always free at exit because pending blocks re-issue.
// - Consume: rsp_valid[i]&rsp_ready[i] at an edge clears rsp_valid[i] and pending[i].
//   - Requester i is re-grantable from the following cycle, never the same cycle.
// - Backpressure: rsp_ready[i]=0 holds rsp_valid[i] and rsp_result[i] indefinitely.
//   - Other requesters are unaffected.
// - Arithmetic: exactly float_mul semantics.
//   - Truncating.
//   - Zero/underflow -> exp 0, mant 0.
//   - Overflow -> exp 2^N_exposant-2, mant all ones.
//   - sign = s1^s2.
// - rsp_ready without rsp_valid is ignored; req_op* are sampled only at the grant edge.
// STRUCTURE
// - float_pack: float typedef, N_mantisse, N_exposant, float_mul; add a tag width constant $clog2(N_REQ).
// - Sub-module float_mul_pipe: PIPE_STAGES-deep register chain {valid,tag,float} after the float_mul call.
//   - No handshake inside float_mul_pipe.
// - Top level: rr arbiter, pending[], per-requester result buffers, busy.
// TESTING (N_REQ=2, PIPE_STAGES=2, N_exposant=8, N_mantisse=23)
// - Single request: req0 2.0*3.0 (0x40000000,0x40400000) in cycle t.
//   -> req_ready=01 at t; rsp_valid[0] at t+2 with 0x40C00000; busy 1 from t+1.
// - Contention after reset: req_valid=11 at t.
//   -> grant 0 at t, grant 1 at t+1.
//   -> rsp_valid[0] at t+2, rsp_valid[1] at t+3.
// - Fairness: both requesters continuously valid, rsp_ready=11 -> grants alternate 0,1,0,1; no starvation.
// - Backpressure: rsp_ready[0]=0 for 5 cycles after a result.
//   -> rsp_result[0] stable, req_ready[0]=0 throughout.
//   -> req1 still granted and returned normally.
// - Saturation/sign:
//   - 1e38*1e38 -> 0x7F7FFFFF.
//   - 1e-38*1e-38 -> 0x00000000.
//   - -1.5*2.0 (0xBFC00000,0x40000000) -> 0xC0400000.
// - Reset mid-op: grant req0 at t, reset=1 at t+1.
//   -> rsp_valid stays 0; busy=0 after the reset edge.
//   -> req0 re-grantable on first cycle after reset deasserts.

Source files
------------

// File: rtl/float_mul_arbiter_pkg.sv
// float_mul_arbiter_pkg: float format, tag width and truncating float multiply shared by the arbiter slice
package float_mul_arbiter_pkg;
    localparam int N_exposant = 8;
    localparam int N_mantisse = 23;
    localparam int FW         = 1 + N_exposant + N_mantisse;
    localparam int N_REQ_MAX  = 8;
    localparam int TAG_W      = $clog2(N_REQ_MAX);
    localparam int BIAS       = 2 ** (N_exposant - 1) - 1;
    localparam int EXP_MAX    = 2 ** N_exposant - 2;
    localparam int PW         = 2 * N_mantisse + 2;

    typedef struct packed {
        logic                  sign;
        logic [N_exposant-1:0] exp;
        logic [N_mantisse-1:0] mant;
    } float_t;

    // Truncating multiply; a zero exponent counts as zero, underflow flushes to zero,
    // overflow saturates to the largest finite magnitude.
    function automatic float_t float_mul(float_t a, float_t b);
        logic [PW-1:0] p;
        logic          n;
        int            e;
        float_t        r;
        p      = PW'({1'b1, a.mant}) * PW'({1'b1, b.mant});
        n      = p[PW-1];
        e      = int'(a.exp) + int'(b.exp) - BIAS + int'(n);
        r.sign = a.sign ^ b.sign;
        r.exp  = e[N_exposant-1:0];
        r.mant = n ? p[PW-2 -: N_mantisse] : p[PW-3 -: N_mantisse];
        if (a.exp == '0 || b.exp == '0 || e <= 0) begin
            r.exp  = '0;
            r.mant = '0;
        end else if (e > EXP_MAX) begin
            r.exp  = N_exposant'(EXP_MAX);
            r.mant = '1;
        end
        return r;
    endfunction
endpackage

// File: rtl/float_mul_arbiter_if.sv
// float_mul_arbiter_if: requester-side bundle of the shared multiplier
// master = requesters (drive req_valid/req_op1/req_op2/rsp_ready), slave = arbiter
interface float_mul_arbiter_if
    import float_mul_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] rsp_valid;
    logic [N_REQ-1:0] rsp_ready;
    float_t           req_op1    [N_REQ];
    float_t           req_op2    [N_REQ];
    float_t           rsp_result [N_REQ];
    logic             busy;

    modport master (
        output req_valid, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );
    modport slave (
        input  req_valid, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );
endinterface

// File: rtl/float_mul_arbiter_pipe.sv
// float_mul_arbiter_pipe: float_mul followed by DEPTH register stages of {valid,tag,product}
// in_valid/in_tag/in_a/in_b -> out_valid/out_tag/out_data after DEPTH cycles; any_valid = some stage occupied
module float_mul_arbiter_pipe
    import float_mul_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  float_t           in_a,
    input  float_t           in_b,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output float_t           out_data,
    output logic             any_valid
);
    float_t prod;

    assign prod = float_mul(in_a, in_b);

    generate
        if (DEPTH == 0) begin : g_comb
            assign out_valid = in_valid;
            assign out_tag   = in_tag;
            assign out_data  = prod;
            assign any_valid = 1'b0;
        end else begin : g_reg
            logic [DEPTH-1:0] v;
            logic [TAG_W-1:0] t [DEPTH];
            float_t           d [DEPTH];
            always_ff @(posedge clk) begin
                v[0] <= in_valid & ~reset;
                t[0] <= in_tag;
                d[0] <= prod;
                for (int s = 1; s < DEPTH; s++) begin
                    v[s] <= v[s-1] & ~reset;
                    t[s] <= t[s-1];
                    d[s] <= d[s-1];
                end
            end
            assign out_valid = v[DEPTH-1];
            assign out_tag   = t[DEPTH-1];
            assign out_data  = d[DEPTH-1];
            assign any_valid = |v;
        end
    endgenerate
endmodule

// File: rtl/float_mul_arbiter.sv
// float_mul_arbiter: round-robin sharing of one pipelined float multiplier between N_REQ requesters
// clk, reset (sync, active-high); bus.slave carries req/rsp handshakes, operands, results and busy
module float_mul_arbiter
    import float_mul_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    float_mul_arbiter_if.slave    bus
);
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] eligible;
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] gnt_tag;
    logic [TAG_W-1:0] out_tag;
    logic             gnt;
    logic             found;
    logic             out_valid;
    logic             pipe_busy;
    float_t           op_a;
    float_t           op_b;
    float_t           out_data;

    assign eligible = bus.req_valid & ~pending & {N_REQ{~reset}};
    assign gnt      = |bus.req_ready;
    assign bus.busy = ~reset & (pipe_busy | (|bus.rsp_valid));

    // Scan rotation order starting at rr_ptr; first eligible requester wins.
    always_comb begin
        bus.req_ready = '0;
        found         = 1'b0;
        gnt_tag       = '0;
        op_a          = '0;
        op_b          = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && eligible[i] && (int'(rr_ptr) + k) % N_REQ == i) begin
                    found            = 1'b1;
                    bus.req_ready[i] = 1'b1;
                    gnt_tag          = TAG_W'(i);
                    op_a             = bus.req_op1[i];
                    op_b             = bus.req_op2[i];
                end
            end
        end
    end

    // The result buffer is the final register of the issue-to-result path.
    float_mul_arbiter_pipe #(.DEPTH(PIPE_STAGES - 1)) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (gnt),
        .in_tag    (gnt_tag),
        .in_a      (op_a),
        .in_b      (op_b),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_data  (out_data),
        .any_valid (pipe_busy)
    );

    // A returning result always finds its buffer free: pending blocks re-issue until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            bus.rsp_valid <= '0;
            rr_ptr        <= '0;
            for (int i = 0; i < N_REQ; i++) bus.rsp_result[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                    pending[i]       <= 1'b0;
                    bus.rsp_valid[i] <= 1'b0;
                end
                if (gnt && gnt_tag == TAG_W'(i)) pending[i] <= 1'b1;
                if (out_valid && out_tag == TAG_W'(i)) begin
                    bus.rsp_valid[i]  <= 1'b1;
                    bus.rsp_result[i] <= out_data;
                end
            end
            if (gnt) rr_ptr <= (int'(gnt_tag) == N_REQ - 1) ? '0 : gnt_tag + 1'b1;
        end
    end
endmodule

// File: tb/tb_float_mul_arbiter.sv
// tb_float_mul_arbiter: directed and randomized checks of the shared float multiplier arbiter
module tb_float_mul_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    float_mul_arbiter_if #(.N_REQ(2)) bus ();

    float_mul_arbiter #(.N_REQ(2), .PIPE_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic real to_real(logic [31:0] f);
        return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0});
    endfunction

    // Reference: exact product in double precision, then truncated back to single.
    function automatic logic [31:0] float_ref(logic [31:0] a, logic [31:0] b);
        real         p;
        logic [63:0] d;
        int          de;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        p  = to_real(a) * to_real(b);
        d  = $realtobits(p);
        de = int'(d[62:52]) - 1023 + 127;
        if (de <= 0) return {s, 31'b0};
        if (de >= 255) return {s, 8'hFE, 23'h7FFFFF};
        return {s, de[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(90, 164));
        return r;
    endfunction

    task automatic drive(input logic r, input logic [1:0] v, input logic [31:0] a0, b0, a1, b1,
                         input logic [1:0] rr);
        @(posedge clk);
        #1;
        reset          = r;
        bus.req_valid  = v;
        bus.req_op1[0] = a0;
        bus.req_op2[0] = b0;
        bus.req_op1[1] = a1;
        bus.req_op2[1] = b1;
        bus.rsp_ready  = rr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 2'b00, 0, 0, 0, 0, 2'b00);
        drive(1, 2'b00, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic test_reset();
        drive(1, 2'b11, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 2'b11);
        drive(1, 2'b11, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 2'b11);
        n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", bus.req_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid); end
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (bus.rsp_result[i] !== 32'h0) begin n_fail++; $display("FAIL reset_result%0d got %h want 0", i, bus.rsp_result[i]); end
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 2'b01, 32'h40000000, 32'h40400000, 0, 0, 2'b00);
        n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", bus.req_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t got %b want 0", bus.busy); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b00);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1 got %b want 1", bus.busy); end
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_early got %b want 00", bus.rsp_valid); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b01);
        n_tests++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp got %b want 01", bus.rsp_valid); end
        n_tests++; if (bus.rsp_result[0] !== 32'h40C00000) begin n_fail++; $display("FAIL single_result got %h want 40c00000", bus.rsp_result[0]); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b00);
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_consume got %b want 00", bus.rsp_valid); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_contention();
        do_reset();
        drive(0, 2'b11, 32'h40000000, 32'h40400000, 32'hBFC00000, 32'h40000000, 2'b11);
        n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL cont_grant0 got %b want 01", bus.req_ready); end
        drive(0, 2'b11, 32'h40000000, 32'h40400000, 32'hBFC00000, 32'h40000000, 2'b11);
        n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL cont_grant1 got %b want 10", bus.req_ready); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b11);
        n_tests++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL cont_rsp0 got %b want 01", bus.rsp_valid); end
        n_tests++; if (bus.rsp_result[0] !== 32'h40C00000) begin n_fail++; $display("FAIL cont_res0 got %h want 40c00000", bus.rsp_result[0]); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b11);
        n_tests++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL cont_rsp1 got %b want 10", bus.rsp_valid); end
        n_tests++; if (bus.rsp_result[1] !== 32'hC0400000) begin n_fail++; $display("FAIL cont_res1 got %h want c0400000", bus.rsp_result[1]); end
    endtask

    task automatic test_fairness();
        int last = -1;
        int cnt[2] = '{0, 0};
        int g;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            drive(0, 2'b11, rand_float(), rand_float(), rand_float(), rand_float(), 2'b11);
            if (bus.req_ready != 2'b00) begin
                g = bus.req_ready[1] ? 1 : 0;
                n_tests++; if (bus.req_ready === 2'b11 || g == last) begin n_fail++; $display("FAIL fair_alt got %b prev %0d want alternate one-hot", bus.req_ready, last); end
                cnt[g]++;
                last = g;
            end
        end
        n_tests++; if (cnt[0] < 5 || cnt[1] < 5) begin n_fail++; $display("FAIL fair_count got %0d/%0d want >=5 each", cnt[0], cnt[1]); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b11);
        drive(0, 2'b00, 0, 0, 0, 0, 2'b11);
        drive(0, 2'b00, 0, 0, 0, 0, 2'b11);
    endtask

    task automatic test_backpressure();
        int grants1 = 0;
        int res1    = 0;
        do_reset();
        drive(0, 2'b01, 32'h40000000, 32'h40400000, 0, 0, 2'b10);
        n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant0 got %b want 01", bus.req_ready); end
        drive(0, 2'b11, 32'h3F800000, 32'h3F800000, 32'hBFC00000, 32'h40000000, 2'b10);
        n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant1 got %b want 10", bus.req_ready); end
        for (int n = 0; n < 5; n++) begin
            drive(0, 2'b11, rand_float(), rand_float(), 32'hBFC00000, 32'h40000000, 2'b10);
            n_tests++; if (bus.rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %b want 1", bus.rsp_valid[0]); end
            n_tests++; if (bus.rsp_result[0] !== 32'h40C00000) begin n_fail++; $display("FAIL bp_hold_result got %h want 40c00000", bus.rsp_result[0]); end
            n_tests++; if (bus.req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_no_regrant got %b want 0", bus.req_ready[0]); end
            if (bus.req_ready[1] === 1'b1) grants1++;
            if (bus.rsp_valid[1] === 1'b1) begin
                res1++;
                n_tests++; if (bus.rsp_result[1] !== 32'hC0400000) begin n_fail++; $display("FAIL bp_res1 got %h want c0400000", bus.rsp_result[1]); end
            end
        end
        n_tests++; if (grants1 != 1 || res1 != 2) begin n_fail++; $display("FAIL bp_req1_flow got grants %0d results %0d want 1 and 2", grants1, res1); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b11);
        drive(0, 2'b00, 0, 0, 0, 0, 2'b11);
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_release got %b want 00", bus.rsp_valid); end
    endtask

    task automatic test_saturation();
        logic [31:0] a   [3] = '{32'h7E967699, 32'h006CE3EE, 32'hBFC00000};
        logic [31:0] b   [3] = '{32'h7E967699, 32'h006CE3EE, 32'h40000000};
        logic [31:0] exp [3] = '{32'h7F7FFFFF, 32'h00000000, 32'hC0400000};
        do_reset();
        for (int j = 0; j < 3; j++) begin
            drive(0, 2'b01, a[j], b[j], 0, 0, 2'b00);
            n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL sat_grant%0d got %b want 01", j, bus.req_ready); end
            drive(0, 2'b00, 0, 0, 0, 0, 2'b00);
            drive(0, 2'b00, 0, 0, 0, 0, 2'b01);
            n_tests++; if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_result[0] !== exp[j]) begin
                n_fail++; $display("FAIL sat_result%0d got v=%b %h want v=1 %h", j, bus.rsp_valid[0], bus.rsp_result[0], exp[j]);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        drive(0, 2'b01, 32'h40000000, 32'h40400000, 0, 0, 2'b01);
        n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_grant got %b want 01", bus.req_ready); end
        drive(1, 2'b01, 32'h3F800000, 32'h40400000, 0, 0, 2'b01);
        n_tests++; if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset got ready %b busy %b want 00 0", bus.req_ready, bus.busy); end
        drive(0, 2'b01, 32'h3F800000, 32'h40400000, 0, 0, 2'b01);
        n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_regrant got %b want 01", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_discard got rsp %b busy %b want 00 0", bus.rsp_valid, bus.busy); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b01);
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_no_stale got %b want 00", bus.rsp_valid); end
        drive(0, 2'b00, 0, 0, 0, 0, 2'b01);
        n_tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result[0] !== 32'h40400000) begin
            n_fail++; $display("FAIL mid_new_result got v=%b %h want v=01 40400000", bus.rsp_valid, bus.rsp_result[0]);
        end
    endtask

    task automatic test_random();
        int          ptr = 0;
        int          cyc = 0;
        int          g;
        int          i;
        int          issue [2] = '{0, 0};
        bit          outst [2] = '{0, 0};
        logic [31:0] expv  [2] = '{0, 0};
        logic [31:0] a     [4];
        logic [1:0]  v, rr, eready;
        logic        ev;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v  = 2'($urandom);
            rr = 2'($urandom);
            for (int j = 0; j < 4; j++) a[j] = rand_float();
            drive(0, v, a[0], a[1], a[2], a[3], rr);
            g = -1;
            for (int k = 0; k < 2; k++) begin
                i = (ptr + k) % 2;
                if (g < 0 && v[i] && !outst[i]) g = i;
            end
            eready = 2'b00;
            if (g >= 0) eready[g] = 1'b1;
            n_tests++; if (bus.req_ready !== eready) begin n_fail++; $display("FAIL rnd_grant cyc %0d got %b want %b", cyc, bus.req_ready, eready); end
            n_tests++; if (bus.busy !== (outst[0] | outst[1])) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, bus.busy, outst[0] | outst[1]); end
            for (int r = 0; r < 2; r++) begin
                ev = outst[r] && cyc >= issue[r] + 2;
                n_tests++; if (bus.rsp_valid[r] !== ev) begin n_fail++; $display("FAIL rnd_valid%0d cyc %0d got %b want %b", r, cyc, bus.rsp_valid[r], ev); end
                if (ev) begin
                    n_tests++; if (bus.rsp_result[r] !== expv[r]) begin n_fail++; $display("FAIL rnd_result%0d cyc %0d got %h want %h", r, cyc, bus.rsp_result[r], expv[r]); end
                end
                if (ev && rr[r]) outst[r] = 1'b0;
            end
            if (g >= 0) begin
                outst[g] = 1'b1;
                issue[g] = cyc;
                expv[g]  = (g == 0) ? float_ref(a[0], a[1]) : float_ref(a[2], a[3]);
                ptr      = (g + 1) % 2;
            end
            cyc++;
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            bus.req_op1[i] = '0;
            bus.req_op2[i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_saturation();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
